// File: rtl/ser_pkg.sv
// Shared definitions for the serial line blocks: receiver state encoding,
// frame format constants and the bit-length clamp.
package ser_pkg;

    localparam int          SER_DATA_BITS   = 8;
    localparam logic [15:0] SER_MIN_BIT_LEN = 16'd4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rcv_state_t;

    // Bit lengths below the minimum would leave no room for a mid-bit sample.
    function automatic logic [15:0] ser_clamp_bit_len(input logic [15:0] b);
        return (b < SER_MIN_BIT_LEN) ? SER_MIN_BIT_LEN : b;
    endfunction

endpackage

// File: rtl/ser_sync.sv
// Two-flop synchronizer for asynchronous serial-side inputs; resets to the
// idle (high) level so a line in reset never looks like a start bit.
module ser_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serrcv.sv
// 8N1 serial receiver front end: mid-bit sampling FSM that delivers each good
// byte with a one-cycle sr_full strobe and flags a low stop bit as frame_err.
module serrcv
    import ser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bit_len,
    input  logic        serial_in,
    output logic        sr_full,
    output logic [7:0]  parallel_out,
    output logic        frame_err,
    output logic        busy
);

    logic                     rx_s;
    rcv_state_t               state_q, state_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [15:0]              bl_q, bl_d;
    logic [2:0]               bitno_q, bitno_d;
    logic [SER_DATA_BITS-1:0] sr_q, sr_d;
    logic [7:0]               par_q, par_d;
    logic                     sr_full_q, sr_full_d;
    logic                     ferr_q, ferr_d;

    logic [15:0] b_new;
    logic [15:0] h_new;
    logic        sample;

    ser_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (serial_in),
        .q_o (rx_s)
    );

    // The clamp precedes the halving, so the half-bit count is at least 2.
    assign b_new  = ser_clamp_bit_len(bit_len);
    assign h_new  = b_new >> 1;
    assign sample = (cnt_q == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bl_q      <= SER_MIN_BIT_LEN;
            bitno_q   <= 3'd0;
            sr_q      <= '0;
            par_q     <= 8'h00;
            sr_full_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bl_q      <= bl_d;
            bitno_q   <= bitno_d;
            sr_q      <= sr_d;
            par_q     <= par_d;
            sr_full_q <= sr_full_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bl_d    = bl_q;
        bitno_d = bitno_q;
        sr_d    = sr_q;
        case (state_q)
            IDLE: begin
                // bit_len is captured here only, so mid-frame edits wait a frame.
                if (!rx_s) begin
                    bl_d    = b_new;
                    cnt_d   = h_new - 16'd1;
                    state_d = START;
                end
            end
            START: begin
                if (!sample) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!rx_s) begin
                    cnt_d   = bl_q - 16'd1;
                    bitno_d = 3'd0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!sample) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    sr_d    = {rx_s, sr_q[SER_DATA_BITS-1:1]};
                    cnt_d   = bl_q - 16'd1;
                    bitno_d = bitno_q + 3'd1;
                    if (bitno_q == 3'(SER_DATA_BITS - 1))
                        state_d = STOP;
                end
            end
            STOP: begin
                if (!sample)
                    cnt_d = cnt_q - 16'd1;
                else
                    state_d = rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                if (rx_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_full_d = (state_q == STOP) && sample && rx_s;
        ferr_d    = (state_q == STOP) && sample && !rx_s;
        par_d     = sr_full_d ? sr_q : par_q;
        busy      = (state_q != IDLE);
    end

    assign sr_full      = sr_full_q;
    assign frame_err    = ferr_q;
    assign parallel_out = par_q;

endmodule
